// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master with slave-error and timeout reporting
//
// Accepts one command at a time on a valid/ready handshake, runs it as an
// APB SETUP + ACCESS transfer, and reports completion with a one-cycle
// rsp_valid pulse. A transfer stuck in ACCESS is abandoned after
// timeoutCycles cycles (0 disables the timeout).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid         command offered
//   cmd_ready         command accepted this cycle (high exactly in IDLE)
//   cmd_write         1 = write, 0 = read
//   cmd_addr          target address
//   cmd_wdata         write data
//   sel, enable       APB select / enable
//   write, addr       APB direction / address
//   wdata             APB write data
//   rdata             APB read data from the slave
//   ready, slverr     APB completion / error from the slave
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         read data of the completed transfer (0 for writes/timeouts)
//   rsp_err           transfer ended with slverr or timeout
//   rsp_timeout       transfer ended by timeout

module apb_master #(
    parameter int addrWidth     = 2,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 sel,
    output logic                 enable,
    output logic                 write,
    output logic [addrWidth-1:0] addr,
    output logic [dataWidth-1:0] wdata,
    input  logic [dataWidth-1:0] rdata,
    input  logic                 ready,
    input  logic                 slverr,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout
);

    localparam int CW = (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    localparam bit TO_EN = (timeoutCycles > 0);
    // Counter value during the last permitted ACCESS cycle.
    localparam logic [CW-1:0] TO_LAST = CW'((timeoutCycles > 0) ? timeoutCycles - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 lat_write, lat_write_nxt;
    logic [addrWidth-1:0] lat_addr, lat_addr_nxt;
    logic [dataWidth-1:0] lat_wdata, lat_wdata_nxt;

    logic                 sel_nxt, enable_nxt, write_nxt;
    logic [addrWidth-1:0] addr_nxt;
    logic [dataWidth-1:0] wdata_nxt;
    logic                 rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [dataWidth-1:0] rsp_rdata_nxt;

    logic timeout_hit;

    // Expires only when ready is low, so a ready on the final cycle wins.
    assign timeout_hit = TO_EN && (state == ACCESS) && !ready && (cnt == TO_LAST);
    assign cmd_ready   = (state == IDLE);

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            sel         <= 1'b0;
            enable      <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lat_write   <= lat_write_nxt;
            lat_addr    <= lat_addr_nxt;
            lat_wdata   <= lat_wdata_nxt;
            sel         <= sel_nxt;
            enable      <= enable_nxt;
            write       <= write_nxt;
            addr        <= addr_nxt;
            wdata       <= wdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (ready || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, the command latch and the
    // timeout counter. APB outputs are computed for the state being entered.
    always_comb begin
        sel_nxt         = 1'b0;
        enable_nxt      = 1'b0;
        write_nxt       = 1'b0;
        addr_nxt        = '0;
        wdata_nxt       = '0;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;
        cnt_nxt         = cnt;
        lat_write_nxt   = lat_write;
        lat_addr_nxt    = lat_addr;
        lat_wdata_nxt   = lat_wdata;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    lat_write_nxt = cmd_write;
                    lat_addr_nxt  = cmd_addr;
                    lat_wdata_nxt = cmd_wdata;
                    sel_nxt       = 1'b1;
                    write_nxt     = cmd_write;
                    addr_nxt      = cmd_addr;
                    wdata_nxt     = cmd_wdata;
                end
            end
            SETUP: begin
                sel_nxt    = 1'b1;
                enable_nxt = 1'b1;
                write_nxt  = lat_write;
                addr_nxt   = lat_addr;
                wdata_nxt  = lat_wdata;
                cnt_nxt    = '0;
            end
            ACCESS: begin
                if (ready) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = slverr;
                    rsp_timeout_nxt = 1'b0;
                    rsp_rdata_nxt   = lat_write ? '0 : rdata;
                end else if (timeout_hit) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_rdata_nxt   = '0;
                end else begin
                    sel_nxt    = 1'b1;
                    enable_nxt = 1'b1;
                    write_nxt  = lat_write;
                    addr_nxt   = lat_addr;
                    wdata_nxt  = lat_wdata;
                    // Saturate so a disabled timeout never wraps.
                    if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master

module tb_apb_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       sel, enable, write;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready, slverr;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err, rsp_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    apb_master #(.addrWidth(2), .dataWidth(8), .timeoutCycles(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .slverr(slverr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic w, input logic [1:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rdata = '0; ready = 1'b0; slverr = 1'b0;
        step(); step();
        reset = 1'b0;
        tests_run++;
        if ({sel, enable, write, addr, wdata} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_apb got %b exp 0", {sel, enable, write, addr, wdata});
        end
        tests_run++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp got %b exp 0", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout});
        end
        step();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        // ready/slverr high throughout, including SETUP, where they must be ignored
        ready = 1'b1; slverr = 1'b1;
        offer(1'b1, 2'd1, 8'h2A);
        step();
        cmd_valid = 1'b0; slverr = 1'b0;
        tests_run++;
        if ({cmd_ready, sel, enable, write, addr, wdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h2A}) begin
            tests_failed++;
            $display("FAIL wr_setup got %h exp %h", {cmd_ready, sel, enable, write, addr, wdata},
                     {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h2A});
        end
        step();
        tests_run++;
        if ({sel, enable, write, addr, wdata, rsp_valid} !== {1'b1, 1'b1, 1'b1, 2'd1, 8'h2A, 1'b0}) begin
            tests_failed++;
            $display("FAIL wr_access got %h exp %h", {sel, enable, write, addr, wdata, rsp_valid},
                     {1'b1, 1'b1, 1'b1, 2'd1, 8'h2A, 1'b0});
        end
        step();
        ready = 1'b0;
        tests_run++;
        if ({sel, enable, addr, wdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}
            !== {1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL wr_rsp got %h exp %h", {sel, enable, addr, wdata, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        step();
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_rsp_pulse got %b exp 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_wait();
        ready = 1'b0; rdata = 8'hAA;
        offer(1'b0, 2'd2, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({sel, enable, write, addr, rsp_valid} !== {1'b1, 1'b1, 1'b0, 2'd2, 1'b0}) begin
                tests_failed++;
                $display("FAIL rd_wait_stable cyc %0d got %b exp %b", i,
                         {sel, enable, write, addr, rsp_valid}, {1'b1, 1'b1, 1'b0, 2'd2, 1'b0});
            end
            if (i == 2) begin
                ready = 1'b1; rdata = 8'h55;
            end
            step();
        end
        ready = 1'b0; rdata = 8'h00;
        tests_run++;
        if ({sel, enable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55}) begin
            tests_failed++;
            $display("FAIL rd_rsp got %h exp %h", {sel, enable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55});
        end
        step();
    endtask

    task automatic test_slverr();
        ready = 1'b0; slverr = 1'b0;
        offer(1'b1, 2'd2, 8'hC3);
        step();
        cmd_valid = 1'b0;
        step();
        ready = 1'b1; slverr = 1'b1;
        step();
        ready = 1'b0; slverr = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL slverr_rsp got %h exp %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {1'b1, 1'b1, 1'b0, 8'h00});
        end
        step(); step(); step();
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b010) begin
            tests_failed++;
            $display("FAIL slverr_hold got %b exp 010", {rsp_valid, rsp_err, rsp_timeout});
        end
    endtask

    task automatic test_timeout();
        int access_cycles;
        ready = 1'b0; rdata = 8'h77;
        offer(1'b0, 2'd3, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        access_cycles = 0;
        for (int i = 0; i < 40 && enable === 1'b1; i++) begin
            access_cycles++;
            step();
        end
        tests_run++;
        if (access_cycles != 16) begin
            tests_failed++;
            $display("FAIL timeout_cycles got %0d exp 16", access_cycles);
        end
        tests_run++;
        if ({sel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL timeout_rsp got %h exp %h", {sel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
        end
        step();
    endtask

    task automatic test_ready_last_cycle();
        ready = 1'b0; rdata = 8'h00;
        offer(1'b0, 2'd1, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        tests_run++;
        if ({sel, enable, rsp_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL last_cycle_access got %b exp 110", {sel, enable, rsp_valid});
        end
        ready = 1'b1; rdata = 8'h3C;
        step();
        ready = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 8'h3C}) begin
            tests_failed++;
            $display("FAIL last_cycle_rsp got %h exp %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {1'b1, 1'b0, 1'b0, 8'h3C});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int first_rsp, second_rsp;
        first_rsp = -1; second_rsp = -1;
        ready = 1'b1; slverr = 1'b0;
        offer(1'b1, 2'd1, 8'h11);
        step();
        // change the offered command while busy; it must not disturb transfer 1
        offer(1'b1, 2'd3, 8'h22);
        step();
        tests_run++;
        if ({enable, addr, wdata} !== {1'b1, 2'd1, 8'h11}) begin
            tests_failed++;
            $display("FAIL b2b_first_access got %h exp %h", {enable, addr, wdata}, {1'b1, 2'd1, 8'h11});
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (rsp_valid === 1'b1) begin
                if (first_rsp < 0) first_rsp = cyc;
                else if (second_rsp < 0) second_rsp = cyc;
            end
            if (cyc == 0) begin
                tests_run++;
                if ({rsp_valid, cmd_ready} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL b2b_accept got %b exp 11", {rsp_valid, cmd_ready});
                end
            end
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                tests_run++;
                if ({sel, enable, addr, wdata} !== {1'b1, 1'b0, 2'd3, 8'h22}) begin
                    tests_failed++;
                    $display("FAIL b2b_second_setup got %h exp %h", {sel, enable, addr, wdata}, {1'b1, 1'b0, 2'd3, 8'h22});
                end
            end
        end
        ready = 1'b0;
        tests_run++;
        if (first_rsp != 0 || second_rsp != 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing got %0d,%0d exp 0,3", first_rsp, second_rsp);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        ready = 1'b0;
        offer(1'b0, 2'd2, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1; ready = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if ({sel, enable, rsp_valid, cmd_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_mid got %b exp 0001", {sel, enable, rsp_valid, cmd_ready});
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid === 1'b1 || sel === 1'b1) pulses++;
        end
        ready = 1'b0;
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet got %0d exp 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_ready_last_cycle();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter addrWidth, default 2: width of the APB address and of cmd_addr.
REQ-002 Parameter dataWidth, default 8: width of all data buses.
REQ-003 Parameter timeoutCycles, default 16: maximum number of ACCESS cycles per transfer; 0 disables the timeout.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1: a command is offered.
REQ-007 Port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-008 Port cmd_write, input, 1: 1 means write, 0 means read.
REQ-009 Port cmd_addr, input, addrWidth: target address.
REQ-010 Port cmd_wdata, input, dataWidth: write data.
REQ-011 Port sel, output, 1: APB select.
REQ-012 Port enable, output, 1: APB enable.
REQ-013 Port write, output, 1: APB direction.
REQ-014 Port addr, output, addrWidth: APB address.
REQ-015 Port wdata, output, dataWidth: APB write data.
REQ-016 Port rdata, input, dataWidth: APB read data.
REQ-017 Port ready, input, 1: APB transfer-complete indication from the slave.
REQ-018 Port slverr, input, 1: APB slave error, sampled together with ready.
REQ-019 Port rsp_valid, output, 1: one-cycle pulse that marks a completed transfer.
REQ-020 Port rsp_rdata, output, dataWidth: read data of the completed transfer.
REQ-021 Port rsp_err, output, 1: the transfer ended with slverr or a timeout.
REQ-022 Port rsp_timeout, output, 1: the transfer ended by timeout.

Function
REQ-023 The block SHALL register all outputs, with no combinational path from any input to any output, except cmd_ready, which SHALL equal (state == IDLE).
REQ-024 The block SHALL implement the states IDLE, SETUP and ACCESS.
REQ-025 IDLE SHALL behave as follows:
- sel=0, enable=0; write, addr and wdata driven to 0.
- If cmd_valid=1, latch cmd_write, cmd_addr and cmd_wdata, then go to SETUP.
REQ-026 SETUP SHALL last exactly one cycle:
- sel=1, enable=0.
- write, addr and wdata driven from the latched command.
- Unconditionally go to ACCESS.
REQ-027 ACCESS SHALL behave as follows:
- sel=1, enable=1.
- write, addr and wdata remain stable.
- Remain in ACCESS until ready=1 is sampled or the timeout expires.
REQ-028 ready and slverr SHALL be sampled only in ACCESS; values present in IDLE or SETUP SHALL be ignored.
REQ-029 On sampling ready=1 in ACCESS, the block SHALL, on the next edge:
- Go to IDLE with sel=0 and enable=0.
- Pulse rsp_valid=1 for one cycle.
- Set rsp_err=slverr and rsp_timeout=0.
- Set rsp_rdata=rdata for reads; set rsp_rdata=0 for writes.
REQ-030 The timeout counter SHALL clear on entry to ACCESS and increment once per ACCESS cycle in which ready=0.
REQ-031 When the counter reaches timeoutCycles (with timeoutCycles>0), the block SHALL, on the next edge:
- Go to IDLE with sel=0 and enable=0.
- Pulse rsp_valid.
- Set rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-032 If ready=1 is sampled in the same cycle in which the timeout would expire, ready SHALL win and the transfer SHALL complete normally.
REQ-033 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next response.
REQ-034 A command MAY be accepted in the same cycle that rsp_valid=1, giving a minimum of 3 cycles per transfer: accept, SETUP, ACCESS.
REQ-035 cmd_valid SHALL be ignored outside IDLE, and no command SHALL be queued.
REQ-036 The timeout counter SHALL be at least clog2(timeoutCycles+1) bits wide and SHALL NOT wrap.

Reset
REQ-037 While reset=1 at an edge, the block SHALL set the following:
- state=IDLE.
- sel, enable, write, addr and wdata all 0.
- rsp_valid, rsp_rdata, rsp_err and rsp_timeout all 0.
- Timeout counter = 0; latched command cleared.
REQ-038 A reset asserted during SETUP or ACCESS SHALL abort the transfer, drop sel and enable at that edge, and generate no rsp_valid.
REQ-039 cmd_ready SHALL read 1 in the first cycle after reset deasserts.

Verification
REQ-040 Write, zero wait: cmd_write=1, addr=1, wdata=0x2A, slave ready in the first ACCESS cycle -> sel high for 2 cycles, enable high for 1 cycle, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
REQ-041 Read with wait states: read addr=2, slave returns ready after 3 ACCESS cycles with rdata=0x55 -> addr and write stable throughout, rsp_rdata=0x55, rsp_err=0.
REQ-042 Slave error: write to addr=2, slave asserts ready=1 and slverr=1 -> rsp_err=1, rsp_timeout=0, single rsp_valid pulse.
REQ-043 Timeout: ready held at 0, timeoutCycles=16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; ready=1 on the 16th ACCESS cycle completes normally instead.
REQ-044 Back-to-back: cmd_valid held high for two commands -> second accepted in the rsp_valid cycle of the first, second SETUP follows immediately, 3-cycle spacing between transfers.
REQ-045 Reset mid-ACCESS: reset=1 during ACCESS -> sel=0 and enable=0 after that edge, no rsp_valid, cmd_ready=1 after reset deasserts.
